// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute sequencer, opcode decode and datapath steering,
// with a memory-ready stall counter that halts the core on a stuck memory cycle.
module mu0_control #(
    parameter int STALL_LIMIT = 15
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Rdy,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic [1:0] M,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       MEM_rd,
    output logic       MEM_wr,
    output logic       Halted,
    output logic       Mem_Err
);
    localparam int CNT_W = $clog2(STALL_LIMIT + 2);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             err_q, err_d;
    logic             mem_cycle;
    logic             timeout;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= FETCH;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign mem_cycle = MEM_rd | MEM_wr;
    assign timeout   = mem_cycle && !Mem_Rdy && (stall_q == CNT_W'(STALL_LIMIT));

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        err_d   = err_q;
        if (Mem_Rdy)
            stall_d = '0;
        else if (mem_cycle && !timeout)
            stall_d = stall_q + 1'b1;

        if (timeout) begin
            err_d   = 1'b1;
            state_d = HALT;
        end else begin
            case (state_q)
                FETCH: if (Mem_Rdy) state_d = EXEC;
                EXEC: begin
                    case (F)
                        4'd0, 4'd1, 4'd2, 4'd3: if (Mem_Rdy) state_d = FETCH;
                        4'd7:                   state_d = HALT;
                        default:                state_d = FETCH;
                    endcase
                end
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        Addr_sel = 1'b0;
        M        = 2'b00;
        PC_En    = 1'b0;
        IR_En    = 1'b0;
        Acc_En   = 1'b0;
        MEM_rd   = 1'b0;
        MEM_wr   = 1'b0;
        Halted   = 1'b0;
        case (state_q)
            FETCH: begin
                MEM_rd = 1'b1;
                M      = 2'b10;
                IR_En  = Mem_Rdy;
                PC_En  = Mem_Rdy;
            end
            EXEC: begin
                case (F)
                    4'd0: begin Addr_sel = 1'b1; MEM_rd = 1'b1; Acc_En = Mem_Rdy; end
                    4'd1: begin Addr_sel = 1'b1; MEM_wr = 1'b1; end
                    4'd2: begin
                        Addr_sel = 1'b1; MEM_rd = 1'b1; X_sel = 1'b1;
                        M = 2'b01; Acc_En = Mem_Rdy;
                    end
                    4'd3: begin
                        Addr_sel = 1'b1; MEM_rd = 1'b1; X_sel = 1'b1;
                        M = 2'b11; Acc_En = Mem_Rdy;
                    end
                    4'd4: begin Y_sel = 1'b1; PC_En = 1'b1; end
                    4'd5: begin Y_sel = 1'b1; PC_En = ~N; end
                    4'd6: begin Y_sel = 1'b1; PC_En = ~Z; end
                    default: ;
                endcase
            end
            HALT:    Halted = 1'b1;
            default: ;
        endcase
        // Selects keep their FETCH values in reset; only enables and strobes are forced off.
        if (!nReset) begin
            PC_En  = 1'b0;
            IR_En  = 1'b0;
            Acc_En = 1'b0;
            MEM_rd = 1'b0;
            MEM_wr = 1'b0;
            Halted = 1'b0;
        end
    end

    assign Mem_Err = err_q;
endmodule

// File: tb/tb_mu0_control.sv
// Scenario bench for mu0_control: each task queues expected output words as it
// drives stimulus and compares them when the DUT outputs are sampled.
module tb_mu0_control;
    logic       Clk;
    logic       nReset;
    logic [3:0] F;
    logic       N, Z, Mem_Rdy;
    logic       X_sel, Y_sel, Addr_sel;
    logic [1:0] M;
    logic       PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, Halted, Mem_Err;

    mu0_control #(.STALL_LIMIT(15)) dut (
        .Clk(Clk), .nReset(nReset), .F(F), .N(N), .Z(Z), .Mem_Rdy(Mem_Rdy),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .M(M),
        .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En),
        .MEM_rd(MEM_rd), .MEM_wr(MEM_wr), .Halted(Halted), .Mem_Err(Mem_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [11:0] v;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  f;
        logic        n, z, rdy;
        logic [11:0] v;
    } step_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [11:0] got;

    assign got = {X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, Halted, Mem_Err};

    function automatic logic [11:0] ov(input logic x, y, a, input logic [1:0] m,
                                       input logic pc, ir, acc, rd, wr, h, e);
        return {x, y, a, m, pc, ir, acc, rd, wr, h, e};
    endfunction

    function automatic logic [11:0] fetch_o(input logic rdy);
        return ov(0, 0, 0, 2'b10, rdy, rdy, 0, 1, 0, 0, 0);
    endfunction

    function automatic logic [11:0] halt_o(input logic e);
        return ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, e);
    endfunction

    function automatic step_t mk(input string name, input logic [3:0] f,
                                 input logic n, z, rdy, input logic [11:0] v);
        step_t s;
        s.name = name; s.f = f; s.n = n; s.z = z; s.rdy = rdy; s.v = v;
        return s;
    endfunction

    task automatic apply(input step_t s);
        exp_t e;
        F = s.f; N = s.n; Z = s.z; Mem_Rdy = s.rdy;
        e.name = s.name; e.v = s.v;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        nReset = 1'b0; Mem_Rdy = 1'b0;
        repeat (2) @(posedge Clk);
        #1 nReset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        step_t s;
        s = mk("reset_hold", 4'd0, 0, 0, 1, ov(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        nReset = 1'b0;
        apply(s);
        #1 e = sb.pop_front(); checks++;
        if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
        @(posedge Clk); #1 nReset = 1'b1;
        apply(mk("reset_fetch_sta", 4'd1, 0, 0, 1, fetch_o(1)));
        @(negedge Clk); e = sb.pop_front(); checks++;
        if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
        @(posedge Clk); #1;
        apply(mk("reset_sta_exec", 4'd1, 0, 0, 0, ov(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0)));
        @(negedge Clk); e = sb.pop_front(); checks++;
        if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
        #2 nReset = 1'b0;
        apply(mk("reset_abort_sta", 4'd1, 0, 0, 0, ov(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0)));
        #1 e = sb.pop_front(); checks++;
        if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
        @(posedge Clk); #1 nReset = 1'b1;
        apply(mk("reset_release", 4'd0, 0, 0, 0, fetch_o(0)));
        @(negedge Clk); e = sb.pop_front(); checks++;
        if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
    endtask

    task automatic test_add();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk("add_fetch",   4'd2, 0, 0, 1, fetch_o(1)));
        st.push_back(mk("add_exec",    4'd2, 0, 0, 1, ov(1, 0, 1, 2'b01, 0, 0, 1, 1, 0, 0, 0)));
        st.push_back(mk("add_refetch", 4'd0, 0, 0, 1, fetch_o(1)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_sub_stall();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk("sub_fetch", 4'd3, 0, 0, 1, fetch_o(1)));
        for (int k = 0; k < 3; k++)
            st.push_back(mk($sformatf("sub_stall%0d", k), 4'd3, 0, 0, 0,
                            ov(1, 0, 1, 2'b11, 0, 0, 0, 1, 0, 0, 0)));
        st.push_back(mk("sub_done",    4'd3, 0, 0, 1, ov(1, 0, 1, 2'b11, 0, 0, 1, 1, 0, 0, 0)));
        st.push_back(mk("sub_refetch", 4'd0, 0, 0, 1, fetch_o(1)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_jumps();
        step_t st[$];
        exp_t  e;
        logic [3:0] jf [5] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd4};
        logic       jn [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       jz [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       jpc[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            st.push_back(mk($sformatf("jmp%0d_fetch", k), jf[k], jn[k], jz[k], 1, fetch_o(1)));
            st.push_back(mk($sformatf("jmp%0d_exec", k), jf[k], jn[k], jz[k], 0,
                            ov(0, 1, 0, 2'b00, jpc[k], 0, 0, 0, 0, 0, 0)));
        end
        st.push_back(mk("nop_fetch",   4'd9, 0, 0, 1, fetch_o(1)));
        st.push_back(mk("nop_exec",    4'd9, 0, 0, 1, ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk("nop_refetch", 4'd0, 0, 0, 0, fetch_o(0)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk("b2b_lda_fetch", 4'd0, 0, 0, 1, fetch_o(1)));
        st.push_back(mk("b2b_lda_exec",  4'd0, 0, 0, 1, ov(0, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0, 0)));
        st.push_back(mk("b2b_sta_fetch", 4'd1, 0, 0, 1, fetch_o(1)));
        st.push_back(mk("b2b_sta_exec",  4'd1, 0, 0, 1, ov(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0)));
        st.push_back(mk("b2b_refetch",   4'd0, 0, 0, 1, fetch_o(1)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_stp();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk("stp_fetch", 4'd7, 0, 0, 1, fetch_o(1)));
        st.push_back(mk("stp_exec",  4'd7, 0, 0, 1, ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 11; k++)
            st.push_back(mk($sformatf("stp_halt%0d", k), 4'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), halt_o(0)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_stall_boundary();
        step_t st[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 15; k++)
            st.push_back(mk($sformatf("bnd_stall%0d", k), 4'd9, 0, 0, 0, fetch_o(0)));
        st.push_back(mk("bnd_rdy",     4'd9, 0, 0, 1, fetch_o(1)));
        st.push_back(mk("bnd_nop",     4'd9, 0, 0, 1, ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0)));
        st.push_back(mk("bnd_refetch", 4'd9, 0, 0, 0, fetch_o(0)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_timeout();
        step_t st[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 16; k++)
            st.push_back(mk($sformatf("tmo_stall%0d", k), 4'd0, 0, 0, 0, fetch_o(0)));
        for (int k = 0; k < 5; k++)
            st.push_back(mk($sformatf("tmo_halt%0d", k), 4'd0, 0, 0, 1'(k % 2), halt_o(1)));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge Clk); e = sb.pop_front(); checks++;
            if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
            @(posedge Clk); #1;
        end
        do_reset();
        apply(mk("tmo_cleared", 4'd0, 0, 0, 0, fetch_o(0)));
        @(negedge Clk); e = sb.pop_front(); checks++;
        if (got !== e.v) $display("FAIL %s got=%h exp=%h", e.name, got, e.v); else passes++;
    endtask

    initial begin
        nReset = 1'b0; F = 4'd0; N = 1'b0; Z = 1'b0; Mem_Rdy = 1'b0;
        test_reset();
        test_add();
        test_sub_stall();
        test_jumps();
        test_back_to_back();
        test_stp();
        test_stall_boundary();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
